// File: rtl/alu_result_stage_pkg.sv
// Shared 6502 status-register definitions: flag bit positions, flag_sel codes, P image helpers.
// Pure declarations; no timing and no flow control.
package alu_result_stage_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    typedef enum logic [1:0] {
        SEL_C = 2'd0,
        SEL_I = 2'd1,
        SEL_D = 2'd2,
        SEL_V = 2'd3
    } flag_sel_e;

    // Only the six real flags are stored; B and bit 5 exist only on the pushed image.
    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    function automatic flags_t unpack_p(input logic [7:0] img);
        flags_t f;
        f.n = img[FLAG_N];
        f.v = img[FLAG_V];
        f.d = img[FLAG_D];
        f.i = img[FLAG_I];
        f.z = img[FLAG_Z];
        f.c = img[FLAG_C];
        return f;
    endfunction

    function automatic logic [7:0] pack_p(input flags_t f, input logic b);
        return {f.n, f.v, 1'b1, b, f.d, f.i, f.z, f.c};
    endfunction

endpackage

// File: rtl/alu_result_stage_decadj.sv
// One nibble of BCD correction: +6 after a decimal add carry, +10 (-6) after a decimal sub borrow.
// Purely combinational, no flow control; wraps modulo 16 with no carry out.
module decadj_nibble (
    input  logic [3:0] nib_i,
    input  logic       carry_i,
    input  logic       add_en_i,
    input  logic       sub_en_i,
    output logic [3:0] nib_o
);

    always_comb begin
        nib_o = nib_i;
        if (add_en_i && carry_i) begin
            nib_o = nib_i + 4'd6;
        end else if (sub_en_i && !carry_i) begin
            nib_o = nib_i + 4'd10;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result hold register with decimal correction, plus ownership of status register P.
// Single-cycle: inputs sampled on an edge are visible after it; no backpressure, one result per cycle.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter bit         CMOS    = 1'b1,
    parameter logic [7:0] P_RESET = 8'h34
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       res_valid,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_hcarry,
    input  logic       alu_ovf,
    input  logic       is_adc,
    input  logic       is_sbc,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_op,
    input  logic       load_p,
    input  logic [7:0] db_in,
    input  logic       flag_wr,
    input  logic [1:0] flag_sel,
    input  logic       flag_val,
    input  logic       brk_push,
    input  logic       brk_ack,
    output logic [7:0] hold_out,
    output logic       hold_valid,
    output logic [7:0] p_out,
    output logic       c_flag,
    output logic       d_flag,
    output logic       i_flag,
    output logic       z_flag,
    output logic       n_flag,
    output logic       v_flag
);

    flags_t     p_q, p_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q;
    logic [7:0] adj;
    logic [7:0] nz_src;
    logic       dec_add, dec_sub;

    // Both opcode strobes at once is illegal; resolve it as ADC.
    assign dec_add = p_q.d & is_adc;
    assign dec_sub = p_q.d & is_sbc & ~is_adc;

    decadj_nibble u_adj_lo (
        .nib_i    (alu_out[3:0]),
        .carry_i  (alu_hcarry),
        .add_en_i (dec_add),
        .sub_en_i (dec_sub),
        .nib_o    (adj[3:0])
    );

    decadj_nibble u_adj_hi (
        .nib_i    (alu_out[7:4]),
        .carry_i  (alu_carry),
        .add_en_i (dec_add),
        .sub_en_i (dec_sub),
        .nib_o    (adj[7:4])
    );

    assign nz_src = CMOS ? adj : alu_out;
    assign hold_d = res_valid ? adj : hold_q;

    // Later assignments override earlier ones, so statement order encodes per-flag priority.
    always_comb begin
        p_d = p_q;
        if (res_valid) begin
            if (upd_c) p_d.c = alu_carry;
            if (upd_v) p_d.v = alu_ovf;
            if (upd_nz) begin
                p_d.n = nz_src[7];
                p_d.z = (nz_src == 8'h00);
            end
            if (bit_op) begin
                p_d.n = db_in[7];
                p_d.v = db_in[6];
                p_d.z = (alu_out == 8'h00);
            end
        end
        if (flag_wr) begin
            case (flag_sel_e'(flag_sel))
                SEL_C:   p_d.c = flag_val;
                SEL_I:   p_d.i = flag_val;
                SEL_D:   p_d.d = flag_val;
                SEL_V:   p_d.v = flag_val;
                default: p_d = p_d;
            endcase
        end
        if (brk_ack) begin
            p_d.i = 1'b1;
            if (CMOS) p_d.d = 1'b0;
        end
        if (load_p) p_d = unpack_p(db_in);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q          <= unpack_p(P_RESET);
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            hold_q       <= hold_d;
            hold_valid_q <= res_valid;
        end
    end

    assign hold_out   = hold_q;
    assign hold_valid = hold_valid_q;
    assign p_out      = pack_p(p_q, brk_push);
    assign c_flag     = p_q.c;
    assign d_flag     = p_q.d;
    assign i_flag     = p_q.i;
    assign z_flag     = p_q.z;
    assign n_flag     = p_q.n;
    assign v_flag     = p_q.v;

    a_adc_sbc_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(res_valid && is_adc && is_sbc));

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a CMOS and an NMOS instance share stimulus; a negedge monitor
// pops hand-computed expectations whenever hold_valid is seen.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       res_valid, alu_carry, alu_hcarry, alu_ovf, is_adc, is_sbc;
    logic       upd_nz, upd_c, upd_v, bit_op, load_p, flag_wr, flag_val, brk_push, brk_ack;
    logic [7:0] alu_out, db_in;
    logic [1:0] flag_sel;

    logic [7:0] hold_1, hold_0, p_1, p_0;
    logic       hv_1, hv_0;
    logic       c_1, d_1, i_1, z_1, n_1, v_1;
    logic       c_0, d_0, i_0, z_0, n_0, v_0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [7:0] hold1;
        logic [7:0] hold0;
        logic [7:0] p1;
        logic [7:0] p0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_result_stage #(.CMOS(1'b1), .P_RESET(8'h34)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .alu_out(alu_out),
        .alu_carry(alu_carry), .alu_hcarry(alu_hcarry), .alu_ovf(alu_ovf),
        .is_adc(is_adc), .is_sbc(is_sbc), .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
        .bit_op(bit_op), .load_p(load_p), .db_in(db_in), .flag_wr(flag_wr),
        .flag_sel(flag_sel), .flag_val(flag_val), .brk_push(brk_push), .brk_ack(brk_ack),
        .hold_out(hold_1), .hold_valid(hv_1), .p_out(p_1),
        .c_flag(c_1), .d_flag(d_1), .i_flag(i_1), .z_flag(z_1), .n_flag(n_1), .v_flag(v_1)
    );

    alu_result_stage #(.CMOS(1'b0), .P_RESET(8'h34)) dut0 (
        .clk(clk), .reset(reset), .res_valid(res_valid), .alu_out(alu_out),
        .alu_carry(alu_carry), .alu_hcarry(alu_hcarry), .alu_ovf(alu_ovf),
        .is_adc(is_adc), .is_sbc(is_sbc), .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
        .bit_op(bit_op), .load_p(load_p), .db_in(db_in), .flag_wr(flag_wr),
        .flag_sel(flag_sel), .flag_val(flag_val), .brk_push(brk_push), .brk_ack(brk_ack),
        .hold_out(hold_0), .hold_valid(hv_0), .p_out(p_0),
        .c_flag(c_0), .d_flag(d_0), .i_flag(i_0), .z_flag(z_0), .n_flag(n_0), .v_flag(v_0)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Flag taps ordered as the stored flags sit in the pushed image: {0,0,N,V,D,I,Z,C}.
    function automatic logic [7:0] taps_of(input logic [7:0] p);
        return {2'b00, p[7], p[6], p[3], p[2], p[1], p[0]};
    endfunction

    always @(negedge clk) begin
        if (!reset && hv_1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: hold_valid with no expected entry, hold_out=%02h", hold_1);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.name, "_hv0"},    {7'd0, hv_0}, 8'h01);
                chk({mon_e.name, "_hold1"},  hold_1, mon_e.hold1);
                chk({mon_e.name, "_hold0"},  hold_0, mon_e.hold0);
                chk({mon_e.name, "_p1"},     p_1, mon_e.p1);
                chk({mon_e.name, "_p0"},     p_0, mon_e.p0);
                chk({mon_e.name, "_taps1"},  {2'b00, n_1, v_1, d_1, i_1, z_1, c_1}, taps_of(mon_e.p1));
                chk({mon_e.name, "_taps0"},  {2'b00, n_0, v_0, d_0, i_0, z_0, c_0}, taps_of(mon_e.p0));
            end
        end
    end

    task automatic clear_inputs();
        res_valid = 0; alu_out = 8'h00; alu_carry = 0; alu_hcarry = 0; alu_ovf = 0;
        is_adc = 0; is_sbc = 0; upd_nz = 0; upd_c = 0; upd_v = 0; bit_op = 0;
        load_p = 0; db_in = 8'h00; flag_wr = 0; flag_sel = 2'd0; flag_val = 0;
        brk_push = 0; brk_ack = 0;
    endtask

    task automatic push(input string name, input logic [7:0] h1, input logic [7:0] h0,
                        input logic [7:0] p1, input logic [7:0] p0);
        exp_t e;
        e.name = name; e.hold1 = h1; e.hold0 = h0; e.p1 = p1; e.p0 = p0;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic set_result(input logic [7:0] v, input logic c, input logic hc, input logic ovf);
        res_valid = 1; alu_out = v; alu_carry = c; alu_hcarry = hc; alu_ovf = ovf;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1;
        #12;
        chk("rst_hold",  hold_1, 8'h00);
        chk("rst_hv",    {7'd0, hv_1}, 8'h00);
        chk("rst_p_b0",  p_1, 8'h24);
        chk("rst_taps",  {2'b00, n_1, v_1, d_1, i_1, z_1, c_1}, 8'h04);
        brk_push = 1;
        #1;
        chk("rst_p_b1",  p_1, 8'h34);
        brk_push = 0;
        reset = 0;
        step();

        // SED; D must not be visible in the same cycle as the write.
        flag_wr = 1; flag_sel = 2'd2; flag_val = 1;
        #1;
        chk("d_same_cycle1", {7'd0, d_1}, 8'h00);
        chk("d_same_cycle0", {7'd0, d_0}, 8'h00);
        step();
        chk("d_after_sed", {6'd0, d_1, d_0}, 8'h03);

        // Decimal 58+46: the decimal half-carry feeds the ALU high nibble, giving raw 0xAE.
        set_result(8'hAE, 1, 1, 0); is_adc = 1; upd_nz = 1; upd_c = 1; upd_v = 1;
        push("adc_bcd", 8'h04, 8'h04, 8'h2D, 8'hAD);
        step();

        // Decimal 40-01 with C=1: binary 0x3F, low-nibble borrow.
        set_result(8'h3F, 1, 0, 0); is_sbc = 1; upd_nz = 1; upd_c = 1; upd_v = 1;
        push("sbc_bcd", 8'h39, 8'h39, 8'h2D, 8'h2D);
        step();

        // Decimal 50+50 -> 00 carry: Z/N from adjusted byte only on CMOS.
        set_result(8'hA0, 1, 0, 1); is_adc = 1; upd_nz = 1; upd_c = 1; upd_v = 1;
        push("adc_zero", 8'h00, 8'h00, 8'h6F, 8'hED);
        step();

        flag_wr = 1; flag_sel = 2'd2; flag_val = 0;
        step();

        // Binary ADC: hcarry must not cause correction when D=0.
        set_result(8'h80, 0, 1, 1); is_adc = 1; upd_nz = 1; upd_c = 1; upd_v = 1;
        push("adc_bin", 8'h80, 8'h80, 8'hE4, 8'hE4);
        step();

        set_result(8'h00, 0, 0, 0); bit_op = 1; upd_nz = 1; db_in = 8'h40;
        push("bit", 8'h00, 8'h00, 8'h66, 8'h66);
        step();

        set_result(8'h00, 0, 0, 0); load_p = 1; db_in = 8'hFF; upd_c = 1; upd_nz = 1; upd_v = 1;
        push("load_p", 8'h00, 8'h00, 8'hEF, 8'hEF);
        step();
        brk_push = 1;
        #1;
        chk("php_p1", p_1, 8'hFF);
        chk("php_p0", p_0, 8'hFF);
        brk_push = 0;

        // brk_ack beats a same-edge CLI; CMOS also drops D.
        brk_ack = 1; flag_wr = 1; flag_sel = 2'd1; flag_val = 0;
        step();

        set_result(8'h55, 0, 0, 0); is_sbc = 1;
        push("probe_sbc", 8'h55, 8'hFF, 8'hE7, 8'hEF);
        step();

        set_result(8'h00, 1, 0, 0); flag_wr = 1; flag_sel = 2'd0; flag_val = 0; upd_c = 1; upd_nz = 1;
        push("clc_nz", 8'h00, 8'h00, 8'h66, 8'h6E);
        step();

        set_result(8'h12, 0, 0, 1); flag_wr = 1; flag_sel = 2'd3; flag_val = 0; upd_v = 1;
        push("clv_v", 8'h12, 8'h12, 8'h26, 8'h2E);
        step();

        // Asynchronous reset between edges, right after a valid result was presented.
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        chk("mid_rst_hold", hold_1, 8'h00);
        chk("mid_rst_hv",   {6'd0, hv_1, hv_0}, 8'h00);
        chk("mid_rst_p1",   p_1, 8'h24);
        chk("mid_rst_p0",   p_0, 8'h24);
        chk("mid_rst_taps", {2'b00, n_0, v_0, d_0, i_0, z_0, c_0}, 8'h04);
        @(posedge clk);
        #2;
        reset = 0;
        step();
        chk("sb_drain", sbq.size() > 255 ? 8'hFF : 8'(sbq.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
